fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_pingpong_ram.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 184 ++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, state encodings and the index bit-reversal helper.
// Also used by fft_256.
package fft_pkg;

    localparam int N    = 256;
    localparam int LOGN = 8;
    localparam int W    = 16;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] b);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = b[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank simple dual-port RAM. The bank select is the address MSB.
// Read data is registered (1-cycle latency) and the storage has no reset.
module fft_pingpong_ram #(
    parameter int N    = fft_pkg::N,
    parameter int LOGN = fft_pkg::LOGN,
    parameter int W    = fft_pkg::W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wbank,
    input  logic [LOGN-1:0]   waddr,
    input  logic [2*W-1:0]    wdata,
    input  logic              re,
    input  logic              rbank,
    input  logic [LOGN-1:0]   raddr,
    output logic [2*W-1:0]    rdata
);

    logic [2*W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[{rbank, raddr}];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage behind fft_256, ping-pong buffered.
// Optional truncated-frame counter port trunc_cnt under `FFT_REORDER_ERRCNT_EN.
module fft_bitrev_reorder #(
    parameter int N    = fft_pkg::N,
    parameter int LOGN = fft_pkg::LOGN,
    parameter int W    = fft_pkg::W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic          sop_in,
    input  logic [W-1:0]  x_re,
    input  logic [W-1:0]  x_im,
    output logic          valid_out,
    output logic          sop_out,
    output logic [W-1:0]  y_re,
    output logic [W-1:0]  y_im
`ifdef FFT_REORDER_ERRCNT_EN
    ,
    output logic [15:0]   trunc_cnt
`endif
);

    import fft_pkg::*;

    // Stream interface (both sides): a sample transfers on every edge where valid
    // is high; there is no ready, so the sink must accept one sample per cycle.
    // sop marks frame index 0 and is meaningful only while valid is high.

    wr_state_t        wr_state_q, wr_state_d;
    logic [LOGN-1:0]  wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic [LOGN-1:0]  wr_rev;
    logic             ram_we;
    logic [LOGN-1:0]  ram_waddr;
    logic             set_full;

    rd_state_t        rd_state_q, rd_state_d;
    logic [LOGN-1:0]  rcnt_q, rcnt_d;
    logic             rbank_q, rbank_d;
    logic             rd_en;
    logic             clr_full;

    logic [1:0]       full_q;
    logic [2*W-1:0]   ram_rdata;
    logic             valid_q, sop_q;

    always_comb begin
        wr_rev = '0;
        for (int i = 0; i < LOGN; i++) begin
            wr_rev[i] = wcnt_q[LOGN-1-i];
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        set_full   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (valid_in && sop_in) begin
                    ram_we     = 1'b1;
                    wcnt_d     = LOGN'(1);
                    wr_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (valid_in) begin
                    ram_we = 1'b1;
                    if (sop_in) begin
                        // Truncation: restart the frame in the same bank.
                        wcnt_d = LOGN'(1);
                    end else begin
                        ram_waddr = wr_rev;
                        wcnt_d    = wcnt_q + LOGN'(1);
                        if (wcnt_q == LOGN'(N - 1)) begin
                            set_full   = 1'b1;
                            wbank_d    = ~wbank_q;
                            wr_state_d = W_IDLE;
                        end
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rcnt_d     = rcnt_q;
        rbank_d    = rbank_q;
        rd_en      = 1'b0;
        clr_full   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_state_d = R_READ;
                    rcnt_d     = '0;
                end
            end
            R_READ: begin
                rd_en  = 1'b1;
                rcnt_d = rcnt_q + LOGN'(1);
                if (rcnt_q == LOGN'(N - 1)) begin
                    clr_full = 1'b1;
                    rbank_d  = ~rbank_q;
                    // Other bank already waiting: continue without a gap.
                    if (!full_q[~rbank_q]) begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
            rd_state_q <= R_IDLE;
            rcnt_q     <= '0;
            rbank_q    <= 1'b0;
            full_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wcnt_q     <= wcnt_d;
            wbank_q    <= wbank_d;
            rd_state_q <= rd_state_d;
            rcnt_q     <= rcnt_d;
            rbank_q    <= rbank_d;
            if (clr_full) begin
                full_q[rbank_q] <= 1'b0;
            end
            if (set_full) begin
                full_q[wbank_q] <= 1'b1;
            end
            valid_q <= rd_en;
            sop_q   <= rd_en && (rcnt_q == '0);
        end
    end

    fft_pingpong_ram #(
        .N    (N),
        .LOGN (LOGN),
        .W    (W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wbank (wbank_q),
        .waddr (ram_waddr),
        .wdata ({x_re, x_im}),
        .re    (rd_en),
        .rbank (rbank_q),
        .raddr (rcnt_q),
        .rdata (ram_rdata)
    );

    // The RAM read register acts as the output register; gating keeps idle outputs at 0.
    assign valid_out = valid_q;
    assign sop_out   = sop_q;
    assign y_re      = valid_q ? ram_rdata[2*W-1:W] : '0;
    assign y_im      = valid_q ? ram_rdata[W-1:0]   : '0;

`ifdef FFT_REORDER_ERRCNT_EN
    logic trunc;
    assign trunc = (wr_state_q == W_FILL) && valid_in && sop_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trunc_cnt <= '0;
        end else if (trunc && (trunc_cnt != 16'hFFFF)) begin
            trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: frame reorder, back-to-back bursts,
// gapped input, truncation, mid-burst reset and sop-less input.
module tb_fft_bitrev_reorder;

    localparam int N      = 256;
    localparam int W      = 16;
    localparam int MAXCAP = 1024;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic          sop_in;
    logic [W-1:0]  x_re;
    logic [W-1:0]  x_im;
    logic          valid_out;
    logic          sop_out;
    logic [W-1:0]  y_re;
    logic [W-1:0]  y_im;
`ifdef FFT_REORDER_ERRCNT_EN
    logic [15:0]   trunc_cnt;
`endif

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sop_in    (sop_in),
        .x_re      (x_re),
        .x_im      (x_im),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .y_re      (y_re),
        .y_im      (y_im)
`ifdef FFT_REORDER_ERRCNT_EN
        ,
        .trunc_cnt (trunc_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [2*W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [W-1:0] cap_re  [MAXCAP];
    logic [W-1:0] cap_im  [MAXCAP];
    logic         cap_sop [MAXCAP];
    int cap_n, rises, sop_cnt, idle_bad, first_cyc;
    logic prev_valid = 1'b0;
    int last_edge;

    typedef struct {
        int           m;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } vec_t;
    vec_t vecs[6];

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (cap_n == 0) first_cyc = cyc;
            if (!prev_valid) rises++;
            if (cap_n < MAXCAP) begin
                cap_re[cap_n]  = y_re;
                cap_im[cap_n]  = y_im;
                cap_sop[cap_n] = sop_out;
            end
            if (sop_out === 1'b1) sop_cnt++;
            cap_n++;
        end else if (sop_out !== 1'b0 || y_re !== '0 || y_im !== '0) begin
            idle_bad++;
        end
        prev_valid = (valid_out === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int tb_rev(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic s, input logic [W-1:0] re, input logic [W-1:0] im);
        valid_in = v;
        sop_in   = s;
        x_re     = re;
        x_im     = im;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    task automatic clear_mon();
        cap_n = 0; rises = 0; sop_cnt = 0; idle_bad = 0; first_cyc = -1;
    endtask

    // Sends len samples (sop on sample 0) with value base+n; a full frame queues its expectation.
    task automatic send_frame(input int base, input int gap, input int len);
        for (int n = 0; n < len; n++) begin
            step(1'b1, (n == 0), W'(base + n), W'(-(base + n)));
            if (n != len - 1) idle(gap);
        end
        last_edge = cyc;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        if (len == N) begin
            for (int m = 0; m < N; m++) begin
                int v = base + tb_rev(m);
                exp_q.push_back({W'(v), W'(-v)});
            end
        end
    endtask

    task automatic check_burst(input string name, input int exp_n);
        logic [2*W-1:0] e;
        chk({name, "_len"}, cap_n, exp_n);
        chk({name, "_bursts"}, rises, 1);
        chk({name, "_idle_zero"}, idle_bad, 0);
        for (int i = 0; i < cap_n && i < MAXCAP; i++) begin
            if (exp_q.size() == 0) begin
                chk({name, "_extra"}, i, exp_n);
                break;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_data%0d", name, i), {cap_re[i], cap_im[i]}, e);
        end
        chk({name, "_exp_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{0,   16'd0,   16'd0};
        vecs[1] = '{1,   16'd128, -16'd128};
        vecs[2] = '{2,   16'd64,  -16'd64};
        vecs[3] = '{3,   16'd192, -16'd192};
        vecs[4] = '{100, 16'd38,  -16'd38};
        vecs[5] = '{255, 16'd255, -16'd255};

        rst_n = 1'b0; valid_in = 1'b0; sop_in = 1'b0; x_re = '0; x_im = '0;
        clear_mon();
        do_reset();

        // reset state
        chk("rst_valid", valid_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_re", y_re, 0);
        chk("rst_im", y_im, 0);
`ifdef FFT_REORDER_ERRCNT_EN
        chk("rst_trunc", trunc_cnt, 0);
`endif

        // single contiguous frame
        clear_mon();
        send_frame(0, 0, N);
        idle(N + 20);
        chk("single_latency", first_cyc, last_edge + 2);
        chk("single_sop0", cap_sop[0], 1);
        chk("single_sopcnt", sop_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec_re_m%0d", vecs[i].m), cap_re[vecs[i].m], vecs[i].re);
            chk($sformatf("vec_im_m%0d", vecs[i].m), cap_im[vecs[i].m], vecs[i].im);
        end
        check_burst("single", N);

        // three frames back-to-back
        clear_mon();
        send_frame(0, 0, N);
        send_frame(1000, 0, N);
        send_frame(2000, 0, N);
        idle(N + 20);
        chk("b2b_sop0", cap_sop[0], 1);
        chk("b2b_sop256", cap_sop[256], 1);
        chk("b2b_sop512", cap_sop[512], 1);
        chk("b2b_sopcnt", sop_cnt, 3);
        check_burst("b2b", 3 * N);

        // valid on alternate cycles
        clear_mon();
        send_frame(300, 1, N);
        idle(N + 20);
        chk("alt_latency", first_cyc, last_edge + 2);
        chk("alt_sop0", cap_sop[0], 1);
        check_burst("alt", N);

        // truncated frame at sample 100 followed by a full frame
        do_reset();
        clear_mon();
        send_frame(5000, 0, 100);
        send_frame(7000, 0, N);
        idle(N + 20);
        chk("trunc_sopcnt", sop_cnt, 1);
`ifdef FFT_REORDER_ERRCNT_EN
        chk("trunc_cnt", trunc_cnt, 1);
`endif
        check_burst("trunc", N);

        // reset pulse during output sample 50
        clear_mon();
        send_frame(0, 0, N);
        exp_q.delete();
        repeat (52) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_sop", sop_out, 0);
        chk("midrst_re", y_re, 0);
        chk("midrst_im", y_im, 0);
        chk("midrst_pre_samples", cap_n, 51);
        rst_n = 1'b1;
        clear_mon();
        idle(N + 20);
        chk("midrst_no_stale", cap_n, 0);
        chk("midrst_idle_zero", idle_bad, 0);
        clear_mon();
        send_frame(42, 0, N);
        idle(N + 20);
        chk("post_rst_latency", first_cyc, last_edge + 2);
        check_burst("post_rst", N);

        // 300 valid samples without sop
        do_reset();
        clear_mon();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, W'(i), W'(-i));
        valid_in = 1'b0;
        idle(N + 20);
        chk("nosop_no_output", cap_n, 0);
        chk("nosop_idle_zero", idle_bad, 0);
`ifdef FFT_REORDER_ERRCNT_EN
        chk("nosop_trunc", trunc_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
